// File: rtl/enc_pkg.sv
// Shared constants and types for the 4-to-2 event encoder.
// Also holds the index-to-one-hot helper used for the pending-bit clear mask.
package enc_pkg;

  localparam int ENC_N     = 4;
  localparam int ENC_IDX_W = 2;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } enc_state_t;

  function automatic logic [ENC_N-1:0] enc_onehot(input logic [ENC_IDX_W-1:0] sel);
    logic [ENC_N-1:0] oh;
    case (sel)
      2'd0:    oh = 4'b0001;
      2'd1:    oh = 4'b0010;
      2'd2:    oh = 4'b0100;
      2'd3:    oh = 4'b1000;
      default: oh = 4'b0000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/prio_enc_4_2.sv
// Combinational 4-to-2 priority encoder: the highest set bit wins.
// sel is forced to 0 when no bit is set, so that case never leaves it undriven.
module prio_enc_4_2
  import enc_pkg::*;
(
  input  logic [ENC_N-1:0]     pend,
  output logic [ENC_IDX_W-1:0] sel,
  output logic                 any
);

  // Highest-index priority select
  always_comb begin
    sel = 2'd0;
    any = 1'b1;
    casez (pend)
      4'b1???: sel = 2'd3;
      4'b01??: sel = 2'd2;
      4'b001?: sel = 2'd1;
      4'b0001: sel = 2'd0;
      default: begin
        sel = 2'd0;
        any = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/event_encoder_4_2.sv
// Sequential 4-to-2 event encoder: sticky pending bits drained highest-first
// as a 2-bit index over valid/ready, with a sticky overflow flag.
module event_encoder_4_2
  import enc_pkg::*;
#(
  parameter int N     = ENC_N,
  parameter int IDX_W = ENC_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     ev,
  output logic [IDX_W-1:0] idx,
  output logic             idx_valid,
  input  logic             idx_ready,
  input  logic             clr_ovf,
  output logic             ovf,
  output logic [N-1:0]     pend
);

  enc_state_t             state_r;
  logic [ENC_IDX_W-1:0]   sel_s;
  logic                   any_s;
  logic                   load_s;
  logic [N-1:0]           clr_mask_s;
  logic                   ovf_set_s;

  prio_enc_4_2 u_prio (
    .pend (pend),
    .sel  (sel_s),
    .any  (any_s)
  );

  // Load decision, clear mask and overflow detection
  always_comb begin
    load_s = any_s && ((state_r == EMPTY) || (idx_valid && idx_ready));
    if (load_s) begin
      clr_mask_s = enc_onehot(sel_s);
    end else begin
      clr_mask_s = {N{1'b0}};
    end
    // A line being loaded this cycle may re-pend without counting as lost
    ovf_set_s = |(ev & pend & ~clr_mask_s);
  end

  // Pending bits, overflow flag and output FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= EMPTY;
      idx       <= {IDX_W{1'b0}};
      idx_valid <= 1'b0;
      ovf       <= 1'b0;
      pend      <= {N{1'b0}};
    end else begin
      pend <= (pend & ~clr_mask_s) | ev;
      if (ovf_set_s) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
      case (state_r)
        EMPTY: begin
          if (load_s) begin
            state_r   <= FULL;
            idx       <= sel_s;
            idx_valid <= 1'b1;
          end
        end
        FULL: begin
          if (idx_ready) begin
            if (load_s) begin
              idx <= sel_s;
            end else begin
              state_r   <= EMPTY;
              idx_valid <= 1'b0;
            end
          end
        end
        default: begin
          state_r   <= EMPTY;
          idx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_event_encoder_4_2.sv
// Self-checking bench for event_encoder_4_2: behavioural reference model,
// per-cycle compare, directed scenarios with literal expectations, random traffic.
module tb_event_encoder_4_2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] ev = 4'b0000;
  logic       idx_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic [1:0] idx;
  logic       idx_valid;
  logic       ovf;
  logic [3:0] pend;

  int vectors = 0;
  int errors  = 0;

  event_encoder_4_2 #(.N(4), .IDX_W(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ev        (ev),
    .idx       (idx),
    .idx_valid (idx_valid),
    .idx_ready (idx_ready),
    .clr_ovf   (clr_ovf),
    .ovf       (ovf),
    .pend      (pend)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] pend;
    logic [1:0] idx;
    logic       valid;
    logic       ovf;
  } model_t;

  model_t m = '0;

  // Reference: one clock of the encoder described as a set of pending lines
  function automatic model_t model_step(model_t cur, logic [3:0] e, logic rdy, logic c);
    model_t nxt = cur;
    int taken = -1;
    logic lost = 1'b0;
    logic handshake = cur.valid && rdy;
    if (cur.pend != 4'b0000 && (!cur.valid || handshake)) begin
      for (int k = 3; k >= 0; k--) begin
        if (taken < 0 && cur.pend[k]) taken = k;
      end
      nxt.idx   = 2'(taken);
      nxt.valid = 1'b1;
    end else if (handshake) begin
      nxt.valid = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      if (e[k] && cur.pend[k] && k != taken) lost = 1'b1;
    end
    if (taken >= 0) nxt.pend[taken] = 1'b0;
    nxt.pend = nxt.pend | e;
    if (lost) nxt.ovf = 1'b1;
    else if (c) nxt.ovf = 1'b0;
    return nxt;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= '0;
    else        m <= model_step(m, ev, idx_ready, clr_ovf);
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    chk("model_valid", {3'b000, idx_valid}, {3'b000, m.valid});
    chk("model_pend", pend, m.pend);
    chk("model_ovf", {3'b000, ovf}, {3'b000, m.ovf});
    if (m.valid) chk("model_idx", {2'b00, idx}, {2'b00, m.idx});
  end

  task automatic step(input logic [3:0] e, input logic r, input logic c);
    @(negedge clk);
    ev = e;
    idx_ready = r;
    clr_ovf = c;
  endtask

  task automatic out_is(input string name, input logic v, input logic [1:0] i, input logic [3:0] p, input logic o);
    chk({name, "_valid"}, {3'b000, idx_valid}, {3'b000, v});
    if (v) chk({name, "_idx"}, {2'b00, idx}, {2'b00, i});
    chk({name, "_pend"}, pend, p);
    chk({name, "_ovf"}, {3'b000, ovf}, {3'b000, o});
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 out_is("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
    chk("reset_idx", {2'b00, idx}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Single event on line 2
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    out_is("single_p1", 1'b0, 2'd0, 4'b0100, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    out_is("single_p2", 1'b1, 2'd2, 4'b0000, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    out_is("single_p3", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Four simultaneous events drain 3,2,1,0
    step(4'b1111, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    for (int k = 3; k >= 0; k--) begin
      step(4'b0000, 1'b1, 1'b0);
      chk("drain_valid", {3'b000, idx_valid}, 4'b0001);
      chk("drain_idx", {2'b00, idx}, 4'(k));
    end
    step(4'b0000, 1'b1, 1'b0);
    chk("drain_end", {3'b000, idx_valid}, 4'b0000);

    // Backpressure holds index 3
    step(4'b1010, 1'b0, 1'b0);
    repeat (5) step(4'b0000, 1'b0, 1'b0);
    out_is("bp_hold", 1'b1, 2'd3, 4'b0010, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    out_is("bp_still", 1'b1, 2'd3, 4'b0010, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    out_is("bp_next", 1'b1, 2'd1, 4'b0000, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    out_is("bp_done", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Overflow set, sticky, clear, and set-beats-clear
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    out_is("ovf_set", 1'b1, 2'd1, 4'b0001, 1'b1);
    repeat (3) step(4'b0000, 1'b0, 1'b0);
    chk("ovf_sticky", {3'b000, ovf}, 4'b0001);
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    chk("ovf_clr", {3'b000, ovf}, 4'b0000);
    step(4'b0001, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b0);
    chk("ovf_set_wins", {3'b000, ovf}, 4'b0001);
    repeat (4) step(4'b0000, 1'b1, 1'b1);
    out_is("ovf_drained", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Re-pend on the load cycle
    step(4'b1000, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    out_is("repend", 1'b1, 2'd3, 4'b1000, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    out_is("repend_second", 1'b1, 2'd3, 4'b0000, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    out_is("repend_done", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Asynchronous reset mid-cycle with a pending index
    step(4'b1110, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    out_is("prerst", 1'b1, 2'd3, 4'b0110, 1'b0);
    #2 rst_n = 1'b0;
    #1 out_is("midrst", 1'b0, 2'd0, 4'b0000, 1'b0);
    chk("midrst_idx", {2'b00, idx}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    idx_ready = 1'b1;
    repeat (3) step(4'b0000, 1'b1, 1'b0);
    out_is("postrst", 1'b0, 2'd0, 4'b0000, 1'b0);

    // Random traffic; the per-cycle compare does the checking
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] e;
      logic r;
      e = 4'($urandom) & 4'($urandom);
      if ((i / 200) % 2 == 0) r = ($urandom % 4) != 0;
      else                    r = ($urandom % 4) == 0;
      step(e, r, ($urandom % 16) == 0);
      if (i % 700 == 350) begin
        #2 rst_n = 1'b0;
        #1 chk("rand_rst_valid", {3'b000, idx_valid}, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    step(4'b0000, 1'b1, 1'b1);
    repeat (6) step(4'b0000, 1'b1, 1'b0);
    out_is("final", 1'b0, 2'd0, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/event_encoder_4_2.md
# event_encoder_4_2

Sequential 4-to-2 event encoder: the encoding counterpart of the team's 2-to-4 one-hot decoder. Single-cycle event pulses on four lines are latched into sticky pending bits and drained one at a time as a 2-bit index over a valid/ready handshake. The highest pending index wins. Repeated events on a line that is still pending are flagged as overflow. It sits in front of any consumer that turns a binary index back into one-hot form, such as the team's decoder.

## Interface
- `N`, default 4: number of event lines. The block is built for exactly 4.
- `IDX_W`, default 2: index width, equal to $clog2(N).
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `ev` input, N bits: event pulses, synchronous to `clk`. Any number of lines may pulse in the same cycle.
- `idx` output, IDX_W bits: encoded index of the event being presented.
- `idx_valid` output, 1 bit: `idx` holds an undelivered event.
- `idx_ready` input, 1 bit: the consumer accepts `idx` this cycle.
- `clr_ovf` input, 1 bit: synchronous clear of `ovf`.
- `ovf` output, 1 bit: sticky flag; an event was lost.
- `pend` output, N bits: pending-bit register, exported for status.

## Operation
- **Reset values:** `pend`=0, `idx`=0, `idx_valid`=0, `ovf`=0, state=EMPTY. Reset may be asserted at any time and clears all state immediately, including an undelivered `idx`.
- **Priority function:** sel = index of the highest set bit of `pend`. It is defined only when `pend`≠0.
- **Load condition:** load = (`pend`≠0) && (state==EMPTY || (`idx_valid` && `idx_ready`)).
- **On load:**
  - `idx` <= sel.
  - `idx_valid` <= 1.
  - Bit sel is cleared in `pend`.
- **Pending update:** `pend` <= (`pend` & ~clr_mask) | `ev`, where clr_mask is the one-hot of sel when load=1 and 0 otherwise. An event arriving on line sel in the same cycle it is loaded re-sets the bit; this is not an overflow.
- **Overflow:**
  - `ovf` <= 1 if any k has `ev[k]` && `pend[k]` && !clr_mask[k].
  - Otherwise `ovf` <= 0 if `clr_ovf`.
  - Set has priority over clear in the same cycle.
  - An event on a line whose index currently sits in `idx` (already loaded, bit cleared) is not an overflow; it re-pends.
- **State machine:** two states.
  - EMPTY: `idx_valid`=0.
  - FULL: `idx_valid`=1.
  - EMPTY→FULL on load.
  - FULL→FULL on handshake with load, or on no handshake.
  - FULL→EMPTY on handshake with `pend`==0.
- **Output stability:** `idx` and `idx_valid` must not change while `idx_valid`=1 and `idx_ready`=0. `idx_ready` is ignored while `idx_valid`=0.

## Timing
- **Latency:** `ev` pulse at edge t sets `pend` at t+1. From EMPTY, `idx_valid` rises at t+2.
- **Throughput:** one index per cycle with `idx_ready` held high and `pend` non-empty (back-to-back, no bubble).
- **Drain order:** four simultaneous events with `idx_ready`=1 deliver indices 3, 2, 1, 0 on four consecutive cycles. `idx_valid` falls on the cycle after index 0 is accepted.
- **Registered outputs:** all outputs are registered; there is no combinational path from input to output.

## Structure
- **Shared package `enc_pkg`:**
  - `ENC_N`=4.
  - `ENC_IDX_W`=2.
  - `enc_state_t` enum {EMPTY, FULL}.
- **Sub-module `prio_enc_4_2`:** combinational, `pend`[3:0] → sel[1:0] plus any. Highest index wins; sel=0 when any=0. The top level contains only registers, the FSM and the overflow logic.

## Test plan
1. **Single event:** reset, then `ev`=4'b0100 for one cycle with `idx_ready`=1 → `idx_valid`=1 with `idx`=2 two cycles later for exactly one cycle; `pend` returns to 0; `ovf`=0.
2. **Simultaneous events:** `ev`=4'b1111 for one cycle with `idx_ready`=1 → `idx` sequence 3, 2, 1, 0 on consecutive valid cycles, then `idx_valid`=0.
3. **Backpressure:** `ev`=4'b1010 with `idx_ready`=0 for 5 cycles → `idx`=3 held stable with `idx_valid`=1 and `pend`=4'b0010. Then raise `idx_ready` → 3 is accepted, then 1.
4. **Overflow:** `idx_ready`=0, then `ev`=4'b0011, then `ev`=4'b0001 two cycles later → `ovf`=1 and stays 1. A `clr_ovf` pulse returns it to 0. A simultaneous `clr_ovf` and new overflow leaves `ovf`=1.
5. **Re-pend on load:** `pend`=4'b1000 in EMPTY and `ev`=4'b1000 on the load cycle → `idx`=3 valid, `pend`=4'b1000 after the edge, `ovf`=0, and a second `idx`=3 is delivered after the handshake.
6. **Reset mid-operation:** assert `rst_n`=0 asynchronously mid-cycle while `idx_valid`=1 and `pend`=4'b0110 → all outputs drop to their reset values immediately. After release, no stale index is delivered.
